// File: rtl/pe_pkg.sv
// Shared constants and types for the PE-row partial-sum collector.
package pe_pkg;
   localparam int KW      = 5;
   localparam int PSUM_BW = 19;
   localparam int ACT_BW  = 8;

   typedef logic signed [ACT_BW-1:0] act_t;

   // FSM encoding kept as plain constants so legacy tools can decode the state bus.
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
   localparam state_t DONE  = 2'd3;
endpackage

// File: rtl/psum_fifo.sv
// Output FIFO for requantised activations: power-of-two depth, show-ahead read,
// push while full is accepted only when a pop happens in the same cycle.
module psum_fifo
   import pe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ACT_BW
) (
   input  logic         iCLK,
   input  logic         iRSTn,
   input  logic         iPush,
   input  logic [W-1:0] iData,
   input  logic         iPop,
   output logic [W-1:0] oData,
   output logic         oFull,
   output logic         oEmpty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign oEmpty  = (cnt_q == '0);
   assign oFull   = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = iPop && !oEmpty;
   assign do_push = iPush && (!oFull || do_pop);
   assign oData   = mem_q[rptr_q];

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (do_push) mem_q[wptr_q] <= iData;
   end
endmodule

// File: rtl/psum_collector.sv
// Collects 5-tap PE-row partial sums, drops warm-up beats, adds bias, rounds,
// shifts and saturates to 8 bits into an output FIFO. Optional ReLU: PSUM_RELU_EN.
module psum_collector
#(
   parameter int PSUM_BW = pe_pkg::PSUM_BW,
   parameter int KW      = pe_pkg::KW,
   parameter int DEPTH   = 4
) (
   input  logic                      iCLK,
   input  logic                      iRSTn,
   input  logic                      iStart,
   input  logic [7:0]                iRowLen,
   input  logic [7:0]                iRowNum,
   input  logic signed [PSUM_BW-1:0] iBias,
   input  logic [3:0]                iShift,
   input  logic                      iPsumValid,
   input  logic signed [PSUM_BW-1:0] iPsum,
   input  logic                      iReady,
   output logic                      oValid,
   output logic signed [7:0]         oData,
   output logic                      oBusy,
   output logic                      oDone,
   output logic                      oOverflow
);
   import pe_pkg::state_t;
   import pe_pkg::act_t;
   import pe_pkg::IDLE;
   import pe_pkg::RUN;
   import pe_pkg::DRAIN;
   import pe_pkg::DONE;

   // One guard bit for the bias add, one more so the rounding add cannot wrap.
   localparam int XW = PSUM_BW + 2;
   localparam logic signed [XW-1:0] SAT_HI = XW'(127);
`ifdef PSUM_RELU_EN
   localparam logic signed [XW-1:0] SAT_LO = XW'(0);
`else
   localparam logic signed [XW-1:0] SAT_LO = XW'(-128);
`endif

   state_t                    state_q, state_d;
   logic [7:0]                col_q, col_d;
   logic [7:0]                row_q, row_d;
   logic [7:0]                len_q;
   logic [7:0]                num_q;
   logic signed [PSUM_BW-1:0] bias_q;
   logic [3:0]                shift_q;

   logic                      start_acc;
   logic                      cfg_zero;
   logic                      beat;
   logic                      keep;
   logic                      last_col;
   logic                      last_row;

   logic                      s1_v_q;
   logic signed [PSUM_BW:0]   s1_sum_q, s1_sum_d;
   logic                      s2_v_q;
   act_t                      s2_act_q, s2_act_d;
   logic                      ovf_q;

   logic signed [XW-1:0]      pre_x;
   logic signed [XW-1:0]      rnd_x;
   logic signed [XW-1:0]      shf_x;
   logic signed [XW-1:0]      sat_x;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic [7:0]                fifo_data;

   assign start_acc = (state_q == IDLE) && iStart;
   assign cfg_zero  = (len_q == '0) || (num_q == '0);
   assign beat      = (state_q == RUN) && iPsumValid && !cfg_zero;
   assign last_col  = (col_q == len_q - 8'd1);
   assign last_row  = (row_q == num_q - 8'd1);
   assign keep      = beat && (int'(col_q) >= KW - 1);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = RUN;
               col_d   = '0;
               row_d   = '0;
            end
         end
         RUN: begin
            if (cfg_zero) begin
               state_d = DRAIN;
            end else if (beat) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + 8'd1;
                  if (last_row) state_d = DRAIN;
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         DRAIN: begin
            if (!s1_v_q && !s2_v_q && fifo_empty) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign s1_sum_d = (PSUM_BW+1)'(iPsum) + (PSUM_BW+1)'(bias_q);

   always_comb begin
      pre_x = XW'(s1_sum_q);
`ifdef PSUM_RELU_EN
      if (s1_sum_q[PSUM_BW]) pre_x = '0;
`endif
      rnd_x = pre_x;
      if (shift_q != 4'd0) rnd_x = pre_x + (XW'(1) <<< (shift_q - 4'd1));
      shf_x = rnd_x >>> shift_q;
      sat_x = shf_x;
      if (shf_x > SAT_HI) begin
         sat_x = SAT_HI;
      end else if (shf_x < SAT_LO) begin
         sat_x = SAT_LO;
      end
      s2_act_d = sat_x[7:0];
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         len_q    <= '0;
         num_q    <= '0;
         bias_q   <= '0;
         shift_q  <= '0;
         s1_v_q   <= 1'b0;
         s1_sum_q <= '0;
         s2_v_q   <= 1'b0;
         s2_act_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         if (start_acc) begin
            len_q   <= iRowLen;
            num_q   <= iRowNum;
            bias_q  <= iBias;
            shift_q <= iShift;
         end
         s1_v_q <= keep;
         if (keep) s1_sum_q <= s1_sum_d;
         s2_v_q <= s1_v_q;
         if (s1_v_q) s2_act_q <= s2_act_d;
         // The FIFO itself discards the value; only the sticky flag lives here.
         if (start_acc) begin
            ovf_q <= 1'b0;
         end else if (s2_v_q && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign fifo_pop = oValid && iReady;

   psum_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .iCLK   (iCLK),
      .iRSTn  (iRSTn),
      .iPush  (s2_v_q),
      .iData  (s2_act_q),
      .iPop   (fifo_pop),
      .oData  (fifo_data),
      .oFull  (fifo_full),
      .oEmpty (fifo_empty)
   );

   assign oValid    = !fifo_empty;
   assign oData     = fifo_empty ? '0 : fifo_data;
   assign oBusy     = (state_q == RUN) || (state_q == DRAIN);
   assign oDone     = (state_q == DONE);
   assign oOverflow = ovf_q;
endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 The block SHALL expose parameter PSUM_BW, default 19, the width of the incoming partial sum from the 5-tap PE row.
REQ-002 The block SHALL expose parameter KW, default 5, the kernel width (taps per row).
REQ-003 The block SHALL expose parameter DEPTH, default 4, the output FIFO depth (power of two).
REQ-004 iCLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 iRSTn  input  1  asynchronous active-low reset.
REQ-006 iStart  input  1  one-cycle pulse that latches the configuration and starts a frame.
REQ-007 iRowLen  input  8  input pixels per row, latched at iStart.
REQ-008 iRowNum  input  8  rows per frame, latched at iStart.
REQ-009 iBias  input  PSUM_BW signed  bias, latched at iStart.
REQ-010 iShift  input  4  requantisation right-shift, latched at iStart.
REQ-011 iPsumValid  input  1  iPsum is valid this cycle; the upstream row cannot stall.
REQ-012 iPsum  input  PSUM_BW signed  partial sum from the PE row.
REQ-013 iReady  input  1  downstream accepts oData.
REQ-014 oValid  output  1  oData holds a result.
REQ-015 oData  output  8 signed  requantised activation.
REQ-016 oBusy  output  1  high in RUN and DRAIN.
REQ-017 oDone  output  1  one-cycle pulse at frame end.
REQ-018 oOverflow  output  1  sticky FIFO overflow flag.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE -> RUN on iStart; iStart in any other state SHALL be ignored.
REQ-021 In RUN, a column counter SHALL count iPsumValid beats from 0 to iRowLen-1, then wrap to 0 and increment the row counter.
REQ-022 Beats with column < KW-1 SHALL be discarded (pipeline warm-up); other beats enter the datapath.
REQ-023 If iRowLen < KW, every beat of the row SHALL be discarded, but rows SHALL still be counted.
REQ-024 The last beat of row iRowNum-1 SHALL cause RUN -> DRAIN.
REQ-025 If iRowNum = 0 or iRowLen = 0, the FSM SHALL go RUN -> DRAIN on the next cycle.
REQ-026 DRAIN SHALL hold until the datapath and FIFO are both empty, then go to DONE.
REQ-027 DONE SHALL assert oDone for exactly one cycle, then return to IDLE.
REQ-028 Datapath stage 1 SHALL register sum = iPsum + iBias at PSUM_BW+1 bits, without overflow.
REQ-029 Datapath stage 2 SHALL compute sum >>> iShift with round-half-up (add 1<<(iShift-1) when iShift > 0), saturate the result to 8 bits, and push it into the FIFO.
REQ-030 Latency SHALL be: with the FIFO empty and iReady high, oValid asserts 3 cycles after the accepted iPsumValid beat.
REQ-031 A FIFO entry SHALL pop when oValid && iReady; oData SHALL be stable while oValid && !iReady.
REQ-032 Push and pop in the same cycle SHALL be legal when full; occupancy is then unchanged.
REQ-033 A push while full with no pop SHALL drop the new value and set oOverflow.
REQ-034 oOverflow SHALL stay set until the next accepted iStart.
REQ-035 iPsumValid outside RUN SHALL be ignored.

Reset
REQ-036 When iRSTn is low, the block SHALL enter IDLE and clear counters, pipeline valids and FIFO pointers.
REQ-037 Under reset, oValid, oBusy, oDone and oOverflow SHALL be 0 and oData SHALL be 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame and discard buffered data, without pulsing oDone.

Configuration
REQ-039 With macro PSUM_RELU_EN defined, negative stage-1 sums SHALL be clamped to 0 before the shift, and saturation SHALL be to the range 0..127.
REQ-040 Without PSUM_RELU_EN, saturation SHALL be to the range -128..127.

Structure
REQ-041 Package pe_pkg SHALL hold KW, PSUM_BW, the FSM state typedef and the 8-bit activation type.
REQ-042 The FIFO SHALL be the sub-module psum_fifo (DEPTH, 8-bit width, full/empty outputs, same clock and reset).

Verification
REQ-043 iRowLen=8, iRowNum=2, iBias=0, iShift=0, iPsum=beat index, iReady=1 -> exactly 8 outputs, values 4..7 twice, oDone once, 3-cycle latency.
REQ-044 iPsum=1000, iBias=24, iShift=3 -> 1024>>3 = 128 saturates to oData=127; iPsum=11, iShift=1 -> oData=6 (rounded).
REQ-045 iPsum=-50, iBias=0, iShift=0 -> oData=0 with PSUM_RELU_EN, -50 without.
REQ-046 iReady held low over a 10-output row -> 4 results held, oOverflow=1, oData stable; oOverflow clears on the next iStart.
REQ-047 iRowLen=3, iRowNum=2 -> no outputs; oDone pulses after the 6th beat plus drain.
REQ-048 iRSTn pulsed low mid-RUN -> all outputs 0, no oDone, FSM in IDLE; a following iStart runs normally.
